// File: rtl/obj_update_scheduler_pkg.sv
// Shared types for the object update scheduler: field codes, update entry, FSM states.
package obj_pkg;

  localparam int OBJ_ROWS     = 4;
  localparam int OBJ_COLS     = 6;
  localparam int OBJ_V_ACTIVE = 480;
  localparam int OBJ_DATA_W   = 32;

  localparam logic [2:0] F_VSTART  = 3'd0;
  localparam logic [2:0] F_HSTART  = 3'd1;
  localparam logic [2:0] F_WIDTH   = 3'd2;
  localparam logic [2:0] F_HEIGHT  = 3'd3;
  localparam logic [2:0] F_VOFFSET = 3'd4;
  localparam logic [2:0] F_HOFFSET = 3'd5;
  localparam logic [2:0] F_VISIBLE = 3'd6;
  localparam logic [2:0] F_COLOR   = 3'd7;

  typedef struct packed {
    logic [1:0]            row;
    logic [2:0]            col;
    logic [2:0]            field;
    logic [OBJ_DATA_W-1:0] data;
  } obj_upd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/obj_update_scheduler_if.sv
// Request bus between game-logic requesters and the update scheduler.
interface obj_update_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*2-1:0]      req_row;
  logic [NUM_REQ*3-1:0]      req_col;
  logic [NUM_REQ*3-1:0]      req_field;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output req_valid, req_row, req_col, req_field, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_row, req_col, req_field, req_data,
    output req_ready
  );
endinterface

// File: rtl/obj_update_scheduler_upd_fifo.sv
// Synchronous FIFO of object update entries; depth must be a power of 2.
module upd_fifo
  import obj_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  obj_upd_t                 din,
  output obj_upd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  obj_upd_t       mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/obj_update_scheduler.sv
// Round-robin object update scheduler committing buffered writes during vblank.
// Optional OBJ_BOUNDS_CHECK_EN discards out-of-grid requests and counts them.
module obj_update_scheduler
  import obj_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int ROWS       = OBJ_ROWS,
  parameter int COLS       = OBJ_COLS,
  parameter int DATA_W     = OBJ_DATA_W,
  parameter int V_ACTIVE   = OBJ_V_ACTIVE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   vCount,
  obj_update_scheduler_if.slave         req,
  output logic                          tbl_wr_en,
  output logic [1:0]                    tbl_row,
  output logic [2:0]                    tbl_col,
  output logic [2:0]                    tbl_field,
  output logic [DATA_W-1:0]             tbl_data,
  output logic                          frame_commit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    err_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t  state;
  sched_state_t  nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          hit;
  logic          xfer;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          vblank;
  logic          vb_q;
  logic          vb_rise;
  obj_upd_t      sel;
  obj_upd_t      head;
  int            idx;

  // First valid requester at or after the pointer, with wrap-around.
  always_comb begin
    hit           = 1'b0;
    gidx          = '0;
    idx           = 0;
    req.req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!hit && req.req_valid[idx]) begin
        hit  = 1'b1;
        gidx = PW'(idx);
      end
    end
    if (hit && !full) req.req_ready[gidx] = 1'b1;
  end

  assign xfer = hit && !full;

  always_comb begin
    sel       = '0;
    sel.row   = req.req_row[gidx*2 +: 2];
    sel.col   = req.req_col[gidx*3 +: 3];
    sel.field = req.req_field[gidx*3 +: 3];
    sel.data  = req.req_data[gidx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end

`ifdef OBJ_BOUNDS_CHECK_EN
  logic in_range;

  assign in_range = (32'(sel.row) < ROWS) && (32'(sel.col) < COLS);
  assign push     = xfer && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (xfer && !in_range && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign push      = xfer;
  assign err_count = '0;
`endif

  upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign vblank  = (vCount >= 32'(V_ACTIVE));
  assign vb_rise = vblank && !vb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      vb_q  <= 1'b0;
    end else begin
      state <= nxt;
      vb_q  <= vblank;
    end
  end

  always_comb begin
    nxt          = state;
    pop          = 1'b0;
    frame_commit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (vb_rise) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        pop = !empty && vblank;
        if (empty || !vblank) nxt = S_DONE;
      end
      S_DONE: begin
        frame_commit = 1'b1;
        nxt          = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // The popped head drives the table in the same cycle it leaves the FIFO.
  assign tbl_wr_en = pop;
  assign tbl_row   = pop ? head.row   : '0;
  assign tbl_col   = pop ? head.col   : '0;
  assign tbl_field = pop ? head.field : '0;
  assign tbl_data  = pop ? head.data  : '0;

endmodule

// File: tb/tb_obj_update_scheduler.sv
// Scoreboard bench for obj_update_scheduler: directed requests, vblank windows.
module tb_obj_update_scheduler;
  import obj_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] vCount = '0;
  logic        tbl_wr_en;
  logic [1:0]  tbl_row;
  logic [2:0]  tbl_col;
  logic [2:0]  tbl_field;
  logic [31:0] tbl_data;
  logic        frame_commit;
  logic [3:0]  fifo_count;
  logic [7:0]  err_count;

  obj_upd_t    exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          writes = 0;
  int          commits = 0;
  logic [31:0] last_data = '0;
  int          w0;
  int          c0;

  always #5 clk = ~clk;

  obj_update_scheduler_if #(.NUM_REQ(3), .DATA_W(32)) rif ();

  obj_update_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .vCount       (vCount),
    .req          (rif),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_row      (tbl_row),
    .tbl_col      (tbl_col),
    .tbl_field    (tbl_field),
    .tbl_data     (tbl_data),
    .frame_commit (frame_commit),
    .fifo_count   (fifo_count),
    .err_count    (err_count)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every table write must match the head of the scoreboard.
  always @(negedge clk) begin
    obj_upd_t e;
    if (tbl_wr_en === 1'b1) begin
      writes++;
      last_data = tbl_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h want none",
                 {tbl_row, tbl_col, tbl_field, tbl_data});
      end else begin
        e = exp_q.pop_front();
        chk("tbl_write", 64'({tbl_row, tbl_col, tbl_field, tbl_data}),
            64'(e));
      end
    end
    if (frame_commit === 1'b1) commits++;
  end

  task automatic send(input int i, input logic [1:0] r, input logic [2:0] c,
                      input logic [2:0] f, input logic [31:0] d,
                      input bit expect_w);
    int  n;
    bit  ok;
    obj_upd_t e;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    rif.req_valid[i]          = 1'b1;
    rif.req_row[i*2 +: 2]     = r;
    rif.req_col[i*3 +: 3]     = c;
    rif.req_field[i*3 +: 3]   = f;
    rif.req_data[i*32 +: 32]  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (rif.req_ready[i] === 1'b1) ok = 1'b1;
      n++;
    end
    chk("accept", 64'(ok), 64'd1);
    if (ok && expect_w) begin
      e = '{row: r, col: c, field: f, data: d};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rif.req_valid[i] = 1'b0;
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    while (frame_commit !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("commit_seen", 64'(n < 100), 64'd1);
  endtask

  // hold < 0 keeps vblank up until the drain window closes by itself.
  task automatic vblank_window(input int hold);
    @(posedge clk); #1; vCount = 32'd479;
    @(posedge clk); #1; vCount = 32'd480;
    if (hold >= 0) begin
      repeat (hold + 1) @(posedge clk);
      #1;
      vCount = 32'd0;
    end
    wait_commit();
    @(posedge clk); #1; vCount = 32'd0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.req_valid = '0;
    rif.req_row   = '0;
    rif.req_col   = '0;
    rif.req_field = '0;
    rif.req_data  = '0;

    // Reset state
    #12;
    chk("rst_wr_en", 64'(tbl_wr_en), 64'd0);
    chk("rst_commit", 64'(frame_commit), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(rif.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: reset with queued entries flushes them
    send(0, 2'd0, 3'd0, F_VSTART, 32'h11, 1'b0);
    send(1, 2'd1, 3'd1, F_HSTART, 32'h22, 1'b0);
    send(2, 2'd2, 3'd2, F_WIDTH,  32'h33, 1'b0);
    chk("t1_count3", 64'(fifo_count), 64'd3);
    #3;
    rst = 1'b0;
    #1;
    chk("t1_flush", 64'(fifo_count), 64'd0);
    chk("t1_outs", 64'({tbl_wr_en, frame_commit, tbl_data, err_count}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    w0 = writes;
    c0 = commits;
    vblank_window(-1);
    chk("t1_writes", 64'(writes - w0), 64'd0);
    chk("t1_commits", 64'(commits - c0), 64'd1);

    // 2: round-robin with all requesters valid
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rif.req_row[i*2 +: 2]    = 2'(i);
      rif.req_col[i*3 +: 3]    = 3'(i);
      rif.req_field[i*3 +: 3]  = 3'(i);
      rif.req_data[i*32 +: 32] = 32'h100 + 32'(i);
    end
    rif.req_valid = 3'b111;
    for (int k = 0; k < 8; k++) begin
      obj_upd_t e;
      @(negedge clk);
      chk("t2_grant", 64'(rif.req_ready), 64'(3'b001 << (k % 3)));
      e = '{row: 2'(k % 3), col: 3'(k % 3), field: 3'(k % 3),
            data: 32'h100 + 32'(k % 3)};
      exp_q.push_back(e);
    end
    repeat (2) begin
      @(negedge clk);
      chk("t2_full_ready", 64'(rif.req_ready), 64'd0);
      chk("t2_full_count", 64'(fifo_count), 64'd8);
    end
    @(posedge clk);
    #1;
    rif.req_valid = '0;

    // 3: full drain, one cycle after vb_rise, 8 consecutive writes
    w0 = writes;
    c0 = commits;
    @(posedge clk); #1; vCount = 32'd479;
    @(posedge clk); #1; vCount = 32'd480;
    @(negedge clk);
    chk("t3_lat0", 64'(tbl_wr_en), 64'd0);
    repeat (8) begin
      @(negedge clk);
      chk("t3_burst", 64'(tbl_wr_en), 64'd1);
    end
    wait_commit();
    @(posedge clk); #1; vCount = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("t3_writes", 64'(writes - w0), 64'd8);
    chk("t3_commits", 64'(commits - c0), 64'd1);
    chk("t3_empty", 64'(fifo_count), 64'd0);

    // 4: short vblank leaves entries for the next frame
    for (int k = 0; k < 8; k++)
      send(2, 2'(k % 4), 3'(k % 6), 3'(k), 32'h400 + 32'(k), 1'b1);
    w0 = writes;
    c0 = commits;
    vblank_window(3);
    chk("t4_writes", 64'(writes - w0), 64'd3);
    chk("t4_count", 64'(fifo_count), 64'd5);
    chk("t4_commits", 64'(commits - c0), 64'd1);
    w0 = writes;
    vblank_window(-1);
    chk("t4_rest", 64'(writes - w0), 64'd5);
    chk("t4_empty", 64'(fifo_count), 64'd0);

    // 5: same target written twice, last write wins
    send(1, 2'd2, 3'd3, F_COLOR, 32'h5, 1'b1);
    send(1, 2'd2, 3'd3, F_COLOR, 32'hA, 1'b1);
    w0 = writes;
    vblank_window(-1);
    chk("t5_writes", 64'(writes - w0), 64'd2);
    chk("t5_last", 64'(last_data), 64'hA);

    // 6: column out of grid
    w0 = writes;
`ifdef OBJ_BOUNDS_CHECK_EN
    send(0, 2'd1, 3'd6, F_VSTART, 32'h77, 1'b0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    vblank_window(-1);
    chk("t6_err", 64'(err_count), 64'd1);
    chk("t6_writes", 64'(writes - w0), 64'd0);
`else
    send(0, 2'd1, 3'd6, F_VSTART, 32'h77, 1'b1);
    chk("t6_count", 64'(fifo_count), 64'd1);
    vblank_window(-1);
    chk("t6_err", 64'(err_count), 64'd0);
    chk("t6_writes", 64'(writes - w0), 64'd1);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obj_update_scheduler.md
Name: obj_update_scheduler

Overview:
- Shares write access to the wall/scroll/player object attribute tables between several game-logic requesters.
- Arbitrates requesters round-robin and buffers their writes in a small FIFO.
- Commits buffered writes only during vertical blanking, so the display compare logic never sees an object half-updated mid-frame.
- Sits between game logic and the object attribute registers that feed the display compare stage; runs on the system clock and takes the VGA vertical count as its frame reference.

Parameters:
- NUM_REQ, 3, number of requesters; requester index 0 is the player logic.
- FIFO_DEPTH, 8, number of update entries buffered; must be a power of 2.
- ROWS, 4, object grid rows.
- COLS, 6, object grid columns.
- DATA_W, 32, attribute data width.
- V_ACTIVE, 480, first vCount value of vertical blanking.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-low.
- vCount  in  32  current VGA line count, already synchronous to clk.
- req_valid  in  NUM_REQ  per-requester update valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_row  in  NUM_REQ*2  packed row index per requester.
- req_col  in  NUM_REQ*3  packed column index per requester.
- req_field  in  NUM_REQ*3  packed attribute select per requester: 0 vStart, 1 hStart, 2 width, 3 height, 4 vOffset, 5 hOffset, 6 visible, 7 color.
- req_data  in  NUM_REQ*DATA_W  packed write data.
- tbl_wr_en  out  1  table write strobe.
- tbl_row  out  2  table write row.
- tbl_col  out  3  table write column.
- tbl_field  out  3  table write attribute select.
- tbl_data  out  DATA_W  table write data.
- frame_commit  out  1  one-cycle pulse when a drain window closes.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_count  out  8  count of rejected out-of-range requests (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, FIFO empty.
- Arbitration (combinational):
  - When the FIFO is not full, req_ready is one-hot to the first valid requester at or after the pointer, searching with wrap-around.
  - When the FIFO is full, or no requester is valid, req_ready is 0.
- Transfer and pointer:
  - A transfer occurs on a clk edge where req_valid[i] and req_ready[i] are both 1.
  - On a transfer the pointer becomes (i+1) mod NUM_REQ.
  - With no transfer the pointer holds.
- vblank is defined as vCount >= V_ACTIVE.
  - vb_rise is a registered detection of vblank going 0 to 1.
  - The value of vCount itself is not registered.
- FSM states:
  - IDLE: FIFO accepts pushes only; no table writes. Moves to DRAIN on vb_rise.
  - DRAIN: pops one entry per cycle while the FIFO is non-empty and vblank is 1. The popped entry drives tbl_* on the same cycle, with tbl_wr_en = 1.
    - Moves to DONE when the FIFO is empty, or when vblank drops. Remaining entries are held for the next frame.
    - Pushes continue during DRAIN. An entry pushed during DRAIN is drained in the same window if time allows.
  - DONE: frame_commit = 1 for exactly one cycle, then back to IDLE.
- DRAIN with an empty FIFO at entry: goes to DONE on the next cycle, so frame_commit still pulses once per frame.
- Simultaneous push and pop:
  - Both are allowed; fifo_count is unchanged.
  - Push is allowed when full only if a pop occurs in the same cycle. Ready is still computed from "not full" only, keeping req_ready independent of the pop.
- Write ordering: writes to the same row/col/field commit in arrival order, so the last write wins.
- Pointer arithmetic: FIFO pointers wrap modulo FIFO_DEPTH.
- err_count saturates at 255.
- Reset asserted mid-DRAIN:
  - The FIFO is flushed and tbl_wr_en drops immediately (asynchronous).
  - No frame_commit is produced.

Optional Feature:
- Macro: OBJ_BOUNDS_CHECK_EN.
- Defined:
  - Requests with row >= ROWS or col >= COLS are still accepted (ready asserted normally) but are discarded, not pushed.
  - Each discarded request increments err_count.
- Undefined:
  - All requests are pushed unchanged.
  - err_count is tied to 0.

Decomposition:
- Shared package obj_pkg contains:
  - field encoding constants F_VSTART through F_COLOR;
  - the obj_upd_t struct {row, col, field, data};
  - default ROWS/COLS/V_ACTIVE constants.
- One sub-module: upd_fifo, a synchronous FIFO of obj_upd_t with push, pop, full, empty and count, using the same clk/rst.

Test Plan:
1. Reset during IDLE with 3 entries queued -> fifo_count = 0, all outputs 0, and the next vb_rise gives zero writes and one frame_commit.
2. Requesters 0, 1, 2 all valid continuously, vCount < 480, FIFO empty at start -> grants 0, 1, 2, 0, 1, 2, 0, 1; FIFO full after 8 cycles; req_ready = 0 thereafter.
3. 8 queued entries, vCount steps 479 -> 480 -> DRAIN begins 1 cycle after vb_rise; 8 consecutive tbl_wr_en cycles in FIFO order; then frame_commit pulses once.
4. 8 queued entries, vblank held for only 3 cycles of DRAIN -> exactly 3 writes; fifo_count = 5; frame_commit pulses; the remaining 5 drain at the next vblank.
5. Requester 1 writes row 2, col 3, color twice (0x5, then 0xA) before vblank -> two writes in order; final tbl_data = 0xA.
6. OBJ_BOUNDS_CHECK_EN defined, request with col = 6 -> accepted but not queued; err_count = 1; no table write at vblank.
